// File: rtl/propose_corner_point_controller.sv
// -----------------------------------------------------------------------------
// propose_corner_point_controller
//
// Sequencer for the corner-point proposal datapath. A start request optionally
// streams clause words from an external clause memory into the clause
// registers, then fires a single reduce/compare pass for the selected variable.
// After the fixed datapath latency it captures the proposed assignment and
// pulses done.
//
// Ports
//   in_clk / in_reset                 clock, asynchronous active-high reset
//   in_start, in_reload               start request (IDLE only), reload clauses
//   in_number_of_clauses              clauses in use (saturates to NC)
//   in_active_clause_mask             per-clause participation mask
//   in_variable_index                 variable to move
//   out_clause_read_request/_address  clause memory read strobe and address
//   in_clause_read_valid/_data        clause memory response
//   out_clause_coefficients/_index/_write  clause register write port
//   out_enable, out_reduce_enable     datapath enable, per-clause reduce enable
//   out_variable_to_be_unchanged_index  held variable index
//   in_new_assignment                 datapath result (signed)
//   out_new_assignment                captured result (signed)
//   out_no_active_clause              effective mask was empty for the pass
//   out_busy, out_done                status, one-cycle completion pulse
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module propose_corner_point_controller #(
    parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 1,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 2,
    parameter int RESULT_LATENCY                      = 2
) (
    input  logic                                                     in_clk,
    input  logic                                                     in_reset,
    input  logic                                                     in_start,
    input  logic                                                     in_reload,
    input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0]                  in_number_of_clauses,
    input  logic [(2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0]           in_active_clause_mask,
    input  logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0]           in_variable_index,
    output logic                                                     out_clause_read_request,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]                out_clause_read_address,
    input  logic                                                     in_clause_read_valid,
    input  logic [((2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX)+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_clause_read_data,
    output logic [((2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX)+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_clause_coefficients,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]                out_clause_index,
    output logic                                                     out_clause_write,
    output logic                                                     out_enable,
    output logic [(2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0]           out_reduce_enable,
    output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0]           out_variable_to_be_unchanged_index,
    input  logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0]       in_new_assignment,
    output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0]       out_new_assignment,
    output logic                                                     out_no_active_clause,
    output logic                                                     out_busy,
    output logic                                                     out_done
);

    localparam int CW     = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
    localparam int VW     = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
    localparam int KW     = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int NC     = 2**KW;
    localparam int WORD_W = ((2**VW) + 1) * CW;
    localparam int LAT_W  = $clog2(RESULT_LATENCY + 1);

    localparam logic [KW:0] NC_N = NC[KW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_REDUCE,
        S_WAIT_RESULT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [KW:0]              num_q, num_d;
    logic [NC-1:0]            mask_q, mask_d;
    logic [KW-1:0]            clause_q, clause_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [VW-1:0]            var_q, var_d;
    logic                     read_req_q, read_req_d;
    logic [WORD_W-1:0]        coef_q, coef_d;
    logic [KW-1:0]            cidx_q, cidx_d;
    logic                     write_q, write_d;
    logic                     enable_q, enable_d;
    logic [NC-1:0]            reduce_en_q, reduce_en_d;
    logic signed [CW-1:0]     assign_q, assign_d;
    logic                     no_active_q, no_active_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [KW:0]              num_sat;
    logic [NC-1:0]            eff_mask;
    logic                     last_clause;

    // Clause count clipped to the number of slots, and the start-time mask
    // restricted to slots below that count.
    always_comb begin
        num_sat = (in_number_of_clauses > NC_N) ? NC_N : in_number_of_clauses;
        for (int k = 0; k < NC; k++) begin
            eff_mask[k] = in_active_clause_mask[k] & (k < int'(num_sat));
        end
    end

    assign last_clause = ({1'b0, clause_q} == (num_q - 1'b1));

    // Outputs are computed for the state being entered so that each strobe is
    // registered and visible during exactly that state's cycle.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        mask_d      = mask_q;
        clause_d    = clause_q;
        lat_d       = lat_q;
        var_d       = var_q;
        coef_d      = coef_q;
        cidx_d      = cidx_q;
        assign_d    = assign_q;
        no_active_d = no_active_q;
        read_req_d  = 1'b0;
        write_d     = 1'b0;
        enable_d    = 1'b0;
        reduce_en_d = '0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    num_d    = num_sat;
                    mask_d   = eff_mask;
                    var_d    = in_variable_index;
                    clause_d = '0;
                    if (in_reload && (num_sat != '0)) begin
                        state_d    = S_LOAD_REQ;
                        read_req_d = 1'b1;
                    end else begin
                        state_d     = S_REDUCE;
                        enable_d    = 1'b1;
                        reduce_en_d = eff_mask;
                    end
                end
            end

            S_LOAD_REQ: begin
                state_d = S_LOAD_WAIT;
            end

            S_LOAD_WAIT: begin
                // The memory may take arbitrarily long; hold here until it answers.
                if (in_clause_read_valid) begin
                    write_d = 1'b1;
                    cidx_d  = clause_q;
                    coef_d  = in_clause_read_data;
                    if (last_clause) begin
                        state_d     = S_REDUCE;
                        enable_d    = 1'b1;
                        reduce_en_d = mask_q;
                    end else begin
                        clause_d   = clause_q + 1'b1;
                        read_req_d = 1'b1;
                        state_d    = S_LOAD_REQ;
                    end
                end
            end

            S_REDUCE: begin
                lat_d   = LAT_W'(RESULT_LATENCY);
                state_d = S_WAIT_RESULT;
            end

            S_WAIT_RESULT: begin
                // Counter runs RESULT_LATENCY..1 over the wait cycles, so the
                // sample at count 1 lands RESULT_LATENCY cycles after REDUCE.
                lat_d = lat_q - 1'b1;
                if (lat_q == LAT_W'(1)) begin
                    assign_d    = in_new_assignment;
                    no_active_d = (mask_q == '0);
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            mask_q      <= '0;
            clause_q    <= '0;
            lat_q       <= '0;
            var_q       <= '0;
            read_req_q  <= 1'b0;
            coef_q      <= '0;
            cidx_q      <= '0;
            write_q     <= 1'b0;
            enable_q    <= 1'b0;
            reduce_en_q <= '0;
            assign_q    <= '0;
            no_active_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            mask_q      <= mask_d;
            clause_q    <= clause_d;
            lat_q       <= lat_d;
            var_q       <= var_d;
            read_req_q  <= read_req_d;
            coef_q      <= coef_d;
            cidx_q      <= cidx_d;
            write_q     <= write_d;
            enable_q    <= enable_d;
            reduce_en_q <= reduce_en_d;
            assign_q    <= assign_d;
            no_active_q <= no_active_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_clause_read_request            = read_req_q;
    assign out_clause_read_address            = clause_q;
    assign out_clause_coefficients            = coef_q;
    assign out_clause_index                   = cidx_q;
    assign out_clause_write                   = write_q;
    assign out_enable                         = enable_q;
    assign out_reduce_enable                  = reduce_en_q;
    assign out_variable_to_be_unchanged_index = var_q;
    assign out_new_assignment                 = assign_q;
    assign out_no_active_clause               = no_active_q;
    assign out_busy                           = busy_q;
    assign out_done                           = done_q;

endmodule

// File: tb/tb_propose_corner_point_controller.sv
module tb_propose_corner_point_controller;

    localparam int CW = 4;
    localparam int VW = 1;
    localparam int KW = 2;
    localparam int L  = 2;
    localparam int NC = 4;
    localparam int WW = ((2**VW) + 1) * CW;

    logic                 clk;
    logic                 rst;
    logic                 in_start;
    logic                 in_reload;
    logic [KW:0]          in_number_of_clauses;
    logic [NC-1:0]        in_active_clause_mask;
    logic [VW-1:0]        in_variable_index;
    logic                 out_clause_read_request;
    logic [KW-1:0]        out_clause_read_address;
    logic                 in_clause_read_valid;
    logic [WW-1:0]        in_clause_read_data;
    logic [WW-1:0]        out_clause_coefficients;
    logic [KW-1:0]        out_clause_index;
    logic                 out_clause_write;
    logic                 out_enable;
    logic [NC-1:0]        out_reduce_enable;
    logic [VW-1:0]        out_variable_to_be_unchanged_index;
    logic signed [CW-1:0] in_new_assignment;
    logic signed [CW-1:0] out_new_assignment;
    logic                 out_no_active_clause;
    logic                 out_busy;
    logic                 out_done;

    propose_corner_point_controller #(
        .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT   (CW),
        .MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX(VW),
        .MAX_BIT_WIDTH_OF_CLAUSES_INDEX     (KW),
        .RESULT_LATENCY                     (L)
    ) dut (
        .in_clk                            (clk),
        .in_reset                          (rst),
        .in_start                          (in_start),
        .in_reload                         (in_reload),
        .in_number_of_clauses              (in_number_of_clauses),
        .in_active_clause_mask             (in_active_clause_mask),
        .in_variable_index                 (in_variable_index),
        .out_clause_read_request           (out_clause_read_request),
        .out_clause_read_address           (out_clause_read_address),
        .in_clause_read_valid              (in_clause_read_valid),
        .in_clause_read_data               (in_clause_read_data),
        .out_clause_coefficients           (out_clause_coefficients),
        .out_clause_index                  (out_clause_index),
        .out_clause_write                  (out_clause_write),
        .out_enable                        (out_enable),
        .out_reduce_enable                 (out_reduce_enable),
        .out_variable_to_be_unchanged_index(out_variable_to_be_unchanged_index),
        .in_new_assignment                 (in_new_assignment),
        .out_new_assignment                (out_new_assignment),
        .out_no_active_clause              (out_no_active_clause),
        .out_busy                          (out_busy),
        .out_done                          (out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] mem [NC];

    // Observations of one transaction, indexed by cycles after the start cycle.
    logic [KW-1:0]        obs_req_addr[$];
    logic [KW-1:0]        obs_wr_idx[$];
    logic [WW-1:0]        obs_wr_data[$];
    logic signed [CW-1:0] na_hist[$];
    int                   obs_en_n, obs_en_iter, obs_done_n, obs_done_iter;
    logic [NC-1:0]        obs_red_mask;
    logic signed [CW-1:0] obs_na;
    logic                 obs_noact, obs_busy1, obs_busy_after;
    logic [VW-1:0]        obs_vidx;

    // Reference expectations derived from the transaction parameters.
    int                   exp_n, exp_reduce_iter, exp_done_iter;
    logic [NC-1:0]        exp_mask;
    logic                 exp_loads, exp_noact;
    logic signed [CW-1:0] exp_na;

    task automatic run_txn(input logic reload, input logic [KW:0] n, input logic [NC-1:0] mask,
                           input logic [VW-1:0] vidx, input int delay, input int extra_start,
                           input bit poke_done);
        int pend;
        logic [KW-1:0] pend_addr;
        int post;
        bit done_seen;
        obs_req_addr.delete(); obs_wr_idx.delete(); obs_wr_data.delete(); na_hist.delete();
        obs_en_n = 0; obs_en_iter = -1; obs_done_n = 0; obs_done_iter = -1;
        obs_red_mask = 'x; obs_na = 'x; obs_noact = 1'bx; obs_vidx = 'x;
        obs_busy1 = 1'b0; obs_busy_after = 1'b0;

        exp_n = (int'(n) > NC) ? NC : int'(n);
        for (int k = 0; k < NC; k++) exp_mask[k] = mask[k] && (k < exp_n);
        exp_loads       = reload && (exp_n > 0);
        exp_reduce_iter = 1 + (exp_loads ? exp_n * (1 + delay) : 0);
        exp_done_iter   = exp_reduce_iter + L + 1;
        exp_noact       = (exp_mask == '0);

        @(negedge clk);
        in_start = 1'b1; in_reload = reload; in_number_of_clauses = n;
        in_active_clause_mask = mask; in_variable_index = vidx;
        in_new_assignment = CW'($urandom); na_hist.push_back(in_new_assignment);
        pend = -1; pend_addr = '0; post = 0; done_seen = 0;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (out_clause_read_request) begin
                obs_req_addr.push_back(out_clause_read_address);
                pend = i + delay; pend_addr = out_clause_read_address;
            end
            if (out_clause_write) begin
                obs_wr_idx.push_back(out_clause_index);
                obs_wr_data.push_back(out_clause_coefficients);
            end
            if (out_enable) begin
                obs_en_n++; obs_en_iter = i; obs_red_mask = out_reduce_enable;
            end
            if (out_done) begin
                obs_done_n++; obs_done_iter = i; obs_na = out_new_assignment;
                obs_noact = out_no_active_clause; obs_vidx = out_variable_to_be_unchanged_index;
            end
            if (i == 1) obs_busy1 = out_busy;
            if (done_seen && out_busy) obs_busy_after = 1'b1;
            in_start = (i == extra_start) || (poke_done && out_done);
            in_reload = $urandom_range(0, 1); in_number_of_clauses = 3'($urandom);
            in_active_clause_mask = 4'($urandom); in_variable_index = VW'($urandom);
            in_clause_read_valid = (i == pend);
            in_clause_read_data  = (i == pend) ? mem[pend_addr] : WW'($urandom);
            in_new_assignment = CW'($urandom); na_hist.push_back(in_new_assignment);
            if (out_done) done_seen = 1;
            if (done_seen) post++;
            if (post > 4) break;
        end
        in_start = 1'b0; in_clause_read_valid = 1'b0;
        exp_na = (exp_reduce_iter + L < na_hist.size()) ? na_hist[exp_reduce_iter + L] : 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_start = 0; in_reload = 0; in_number_of_clauses = 0;
        in_active_clause_mask = 0; in_variable_index = 0; in_clause_read_valid = 0;
        in_clause_read_data = 0; in_new_assignment = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_clause_read_request, out_clause_read_address, out_clause_coefficients, out_clause_index,
             out_clause_write, out_enable, out_reduce_enable, out_variable_to_be_unchanged_index,
             out_new_assignment, out_no_active_clause, out_busy, out_done} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero (busy=%0b done=%0b), required all 0", out_busy, out_done);
        end
    endtask

    task automatic test_reload_full();
        mem[0] = 12'h111; mem[1] = 12'h222; mem[2] = 12'h333; mem[3] = 12'h444;
        run_txn(1'b1, 3'd4, 4'b1111, 1'b0, 1, -1, 0);
        checks++;
        if (obs_wr_idx.size() !== 4) begin errors++; $display("FAIL full_write_count: got %0d required 4", obs_wr_idx.size()); end
        for (int k = 0; k < 4 && k < obs_wr_idx.size(); k++) begin
            checks++;
            if (obs_wr_idx[k] !== KW'(k) || obs_wr_data[k] !== mem[k]) begin
                errors++; $display("FAIL full_write_%0d: got idx=%0d data=%h required idx=%0d data=%h", k, obs_wr_idx[k], obs_wr_data[k], k, mem[k]);
            end
        end
        checks++;
        if (obs_en_n !== 1 || obs_red_mask !== 4'b1111) begin errors++; $display("FAIL full_reduce: got n=%0d mask=%b required 1 1111", obs_en_n, obs_red_mask); end
        checks++;
        if (obs_done_n !== 1 || obs_done_iter !== exp_done_iter) begin errors++; $display("FAIL full_done: got n=%0d at %0d required 1 at %0d", obs_done_n, obs_done_iter, exp_done_iter); end
        checks++;
        if (obs_na !== exp_na) begin errors++; $display("FAIL full_assignment: got %0d required %0d", obs_na, exp_na); end
    endtask

    task automatic test_no_reload();
        run_txn(1'b0, 3'd4, 4'b0101, 1'b1, 1, -1, 0);
        checks++;
        if (obs_req_addr.size() !== 0) begin errors++; $display("FAIL noreload_reqs: got %0d required 0", obs_req_addr.size()); end
        checks++;
        if (obs_red_mask !== 4'b0101 || obs_en_iter !== 1) begin errors++; $display("FAIL noreload_reduce: got %b at %0d required 0101 at 1", obs_red_mask, obs_en_iter); end
        checks++;
        if (obs_vidx !== 1'b1) begin errors++; $display("FAIL noreload_vidx: got %0d required 1", obs_vidx); end
        checks++;
        if (obs_done_iter !== L + 2) begin errors++; $display("FAIL noreload_latency: got %0d required %0d", obs_done_iter, L + 2); end
        checks++;
        if (obs_busy1 !== 1'b1 || obs_na !== exp_na || obs_noact !== 1'b0) begin
            errors++; $display("FAIL noreload_result: got busy=%0b na=%0d noact=%0b required 1 %0d 0", obs_busy1, obs_na, obs_noact, exp_na);
        end
    endtask

    task automatic test_partial();
        for (int k = 0; k < NC; k++) mem[k] = WW'($urandom);
        run_txn(1'b1, 3'd2, 4'b1111, 1'b0, 1, -1, 0);
        checks++;
        if (obs_req_addr.size() !== 2) begin errors++; $display("FAIL partial_reqs: got %0d required 2", obs_req_addr.size()); end
        for (int k = 0; k < obs_req_addr.size() && k < 2; k++) begin
            checks++;
            if (obs_req_addr[k] !== KW'(k)) begin errors++; $display("FAIL partial_addr_%0d: got %0d required %0d", k, obs_req_addr[k], k); end
        end
        checks++;
        if (obs_red_mask !== 4'b0011) begin errors++; $display("FAIL partial_reduce: got %b required 0011", obs_red_mask); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < NC; k++) mem[k] = WW'($urandom);
        run_txn(1'b1, 3'd7, 4'b0000, 1'b0, 1, -1, 0);
        checks++;
        if (obs_wr_idx.size() !== 4) begin errors++; $display("FAIL sat_loads: got %0d required 4", obs_wr_idx.size()); end
        checks++;
        if (obs_en_n !== 1 || obs_red_mask !== 4'b0000) begin errors++; $display("FAIL sat_reduce: got n=%0d mask=%b required 1 0000", obs_en_n, obs_red_mask); end
        checks++;
        if (obs_noact !== 1'b1) begin errors++; $display("FAIL sat_noactive: got %0b required 1", obs_noact); end
    endtask

    task automatic test_stall_busy_start();
        for (int k = 0; k < NC; k++) mem[k] = WW'($urandom);
        run_txn(1'b1, 3'd3, 4'b0110, 1'b1, 5, 3, 1);
        checks++;
        if (obs_done_n !== 1 || obs_done_iter !== exp_done_iter) begin errors++; $display("FAIL stall_done: got n=%0d at %0d required 1 at %0d", obs_done_n, obs_done_iter, exp_done_iter); end
        checks++;
        if (obs_req_addr.size() !== 3 || obs_wr_idx.size() !== 3) begin errors++; $display("FAIL stall_loads: got reqs=%0d writes=%0d required 3 3", obs_req_addr.size(), obs_wr_idx.size()); end
        checks++;
        if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL stall_restart: busy after done got %0b required 0", obs_busy_after); end
    endtask

    task automatic test_async_reset_mid_load();
        @(negedge clk);
        in_start = 1; in_reload = 1; in_number_of_clauses = 3'd4; in_active_clause_mask = 4'hF; in_variable_index = 1;
        @(negedge clk);
        in_start = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_busy !== 1'b1 || out_variable_to_be_unchanged_index !== 1'b1) begin
            errors++; $display("FAIL midload_busy: got busy=%0b vidx=%0d required 1 1", out_busy, out_variable_to_be_unchanged_index);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_clause_read_request, out_clause_read_address, out_clause_coefficients, out_clause_index,
             out_clause_write, out_enable, out_reduce_enable, out_variable_to_be_unchanged_index,
             out_new_assignment, out_no_active_clause, out_busy, out_done} !== '0) begin
            errors++; $display("FAIL async_reset_outputs: busy=%0b vidx=%0d coef=%h required all 0", out_busy, out_variable_to_be_unchanged_index, out_clause_coefficients);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NC; k++) mem[k] = WW'($urandom);
        run_txn(1'b1, 3'd4, 4'b1010, 1'b0, 1, -1, 0);
        checks++;
        if (obs_wr_idx.size() !== 4 || obs_wr_idx[0] !== '0 || obs_wr_data[0] !== mem[0]) begin
            errors++; $display("FAIL after_reset_load: got writes=%0d first idx=%0d required 4 from idx 0", obs_wr_idx.size(), obs_wr_idx.size() > 0 ? obs_wr_idx[0] : 2'd0);
        end
        checks++;
        if (obs_done_iter !== exp_done_iter || obs_red_mask !== 4'b1010) begin
            errors++; $display("FAIL after_reset_done: got %0d mask=%b required %0d 1010", obs_done_iter, obs_red_mask, exp_done_iter);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            logic rl; logic [KW:0] n; logic [NC-1:0] m; logic [VW-1:0] v; int d; bit ok;
            rl = $urandom_range(0, 1); n = 3'($urandom); m = 4'($urandom); v = VW'($urandom);
            d = $urandom_range(1, 3);
            for (int k = 0; k < NC; k++) mem[k] = WW'($urandom);
            run_txn(rl, n, m, v, d, $urandom_range(2, 3), $urandom_range(0, 1) == 1);
            ok = (obs_req_addr.size() == (exp_loads ? exp_n : 0)) && (obs_wr_idx.size() == (exp_loads ? exp_n : 0));
            for (int k = 0; k < obs_wr_idx.size() && ok; k++)
                if (obs_req_addr[k] !== KW'(k) || obs_wr_idx[k] !== KW'(k) || obs_wr_data[k] !== mem[k]) ok = 0;
            checks++;
            if (!ok) begin errors++; $display("FAIL rand%0d_loads: got reqs=%0d writes=%0d required %0d", t, obs_req_addr.size(), obs_wr_idx.size(), exp_loads ? exp_n : 0); end
            checks++;
            if (obs_en_n !== 1 || obs_en_iter !== exp_reduce_iter || obs_red_mask !== exp_mask) begin
                errors++; $display("FAIL rand%0d_reduce: got n=%0d at %0d mask=%b required 1 at %0d mask=%b", t, obs_en_n, obs_en_iter, obs_red_mask, exp_reduce_iter, exp_mask);
            end
            checks++;
            if (obs_done_n !== 1 || obs_done_iter !== exp_done_iter || obs_busy_after !== 1'b0) begin
                errors++; $display("FAIL rand%0d_done: got n=%0d at %0d required 1 at %0d", t, obs_done_n, obs_done_iter, exp_done_iter);
            end
            checks++;
            if (obs_na !== exp_na || obs_noact !== exp_noact || obs_vidx !== v) begin
                errors++; $display("FAIL rand%0d_result: got na=%0d noact=%0b vidx=%0d required %0d %0b %0d", t, obs_na, obs_noact, obs_vidx, exp_na, exp_noact, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reload_full();
        test_no_reload();
        test_partial();
        test_saturate();
        test_stall_busy_start();
        test_async_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
